// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, sequencer FSM encoding and opcode legality shared by slice, sequencer and bench
package alu_pkg;
  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_NOT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_AND;
  endfunction
endpackage

// File: rtl/serial_alu_sequencer_if.sv
// serial_alu_sequencer_if: request/result handshakes plus the one-bit slice bus
interface serial_alu_sequencer_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  logic             out_err;
  logic             alu_a;
  logic             alu_b;
  logic             alu_cin;
  logic [2:0]       alu_op;
  logic             alu_result;
  logic             alu_cout;
  modport master (output in_valid, in_a, in_b, in_op, out_ready,
                  input  in_ready, out_valid, out_result, out_carry, out_zero, out_err);
  modport slave  (input  in_valid, in_a, in_b, in_op, out_ready, alu_result, alu_cout,
                  output in_ready, out_valid, out_result, out_carry, out_zero, out_err,
                         alu_a, alu_b, alu_cin, alu_op);
  modport slice  (input  alu_a, alu_b, alu_cin, alu_op,
                  output alu_result, alu_cout);
endinterface

// File: rtl/serial_alu_sequencer_slice.sv
// serial_alu_sequencer_slice: combinational one-bit ALU slice driven by the sequencer
module serial_alu_sequencer_slice
  import alu_pkg::*;
(
  serial_alu_sequencer_if.slice bus
);
  logic w_bx;
  logic w_arith;
  always_comb begin
    w_bx         = (bus.alu_op == OP_SUB) ? ~bus.alu_b : bus.alu_b;
    w_arith      = (bus.alu_op == OP_ADD) || (bus.alu_op == OP_SUB);
    bus.alu_cout = (bus.alu_a & w_bx) | (bus.alu_a & bus.alu_cin) | (w_bx & bus.alu_cin);
    bus.alu_result = (bus.alu_op == OP_MOV) ? bus.alu_a :
                     (bus.alu_op == OP_NOT) ? ~bus.alu_a :
                     w_arith                ? bus.alu_a ^ w_bx ^ bus.alu_cin :
                     (bus.alu_op == OP_OR)  ? bus.alu_a | bus.alu_b :
                     (bus.alu_op == OP_AND) ? bus.alu_a & bus.alu_b : 1'b0;
  end
endmodule

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: steps a one-bit ALU slice LSB-first to execute a WIDTH-bit operation
module serial_alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_alu_sequencer_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, w_res;
  logic [2:0]       r_op;
  logic [IW-1:0]    r_idx;
  logic             r_carry, r_zero, r_err;
  logic             w_busy, w_last, w_accept;
  assign w_busy   = r_state == S_BUSY;
  assign w_last   = r_idx == IW'(WIDTH - 1);
  assign w_accept = bus.in_valid && r_state == S_IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = !bus.in_valid ? S_IDLE : op_legal(bus.in_op) ? S_BUSY : S_DONE;
      S_BUSY:  w_next = w_last ? S_DONE : S_BUSY;
      S_DONE:  w_next = bus.out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready   = r_state == S_IDLE;
    bus.out_valid  = r_state == S_DONE;
    bus.out_result = r_res;
    bus.out_carry  = r_carry;
    bus.out_zero   = r_zero;
    bus.out_err    = r_err;
    bus.alu_a      = w_busy & r_a[r_idx];
    bus.alu_b      = w_busy & r_b[r_idx];
    bus.alu_cin    = w_busy & r_carry;
    bus.alu_op     = w_busy ? r_op : OP_MOV;
  end
  always_comb begin
    w_res        = r_res;
    w_res[r_idx] = bus.alu_result;
  end
  // carry only moves for ADD/SUB, so it reads back as 0 for every other op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_MOV;
      r_idx   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.in_a;
      r_b     <= bus.in_b;
      r_op    <= bus.in_op;
      r_idx   <= '0;
      r_res   <= '0;
      r_carry <= bus.in_op == OP_SUB;
      r_zero  <= !op_legal(bus.in_op);
      r_err   <= !op_legal(bus.in_op);
    end else if (w_busy) begin
      r_res   <= w_res;
      r_idx   <= r_idx + 1'b1;
      r_carry <= (r_op == OP_ADD || r_op == OP_SUB) ? bus.alu_cout : r_carry;
      r_zero  <= w_last ? w_res == '0 : r_zero;
    end
  end
endmodule
